alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Operand and result stage around the multi-cycle datapath ALU. Holds a 32x32 register file and the
//  A/B operand latches, and muxes ALU num1/num2 from them. It also captures the ALU result and the
//  zero/sign flags into ALUOut and flag registers for the next state of the multi-cycle FSM.
//  Sits between instruction decode/control and the ALU; ALU output loops back here.
// PARAMETERS
//  WIDTH       32  datapath width (A, B, ALUOut, regfile entries)
//  REG_ADDR_W  5   register address width; the register file has 2**REG_ADDR_W entries
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  rst         in   1      asynchronous, active-high reset
//  rs_addr     in   5      regfile read port 1 address (feeds A)
//  rt_addr     in   5      regfile read port 2 address (feeds B)
//  reg_we      in   1      regfile write enable
//  reg_waddr   in   5      regfile write address
//  reg_wdata   in   WIDTH  regfile write data
//  ab_en       in   1      latch regfile read data into A and B
//  ALUSrcA     in   2      num1 select: 00 pc, 01 A, 10 {27'b0,shamt}, 11 zero
//  ALUSrcB     in   2      num2 select: 00 B, 01 32'd4, 10 ext_imm, 11 ext_imm<<2
//  pc          in   WIDTH  current program counter
//  imm16       in   16     instruction immediate
//  ext_op      in   1      1 = sign-extend imm16, 0 = zero-extend
//  shamt       in   5      shift amount field
//  num1        out  WIDTH  ALU operand 1 (combinational from selects/latches)
//  num2        out  WIDTH  ALU operand 2 (combinational)
//  alu_result  in   WIDTH  ALU result
//  alu_zero    in   1      ALU zero flag
//  alu_sign    in   1      ALU sign flag
//  out_en      in   1      capture alu_result/flags
//  alu_out     out  WIDTH  registered ALU result (ALUOut)
//  zero_q      out  1      registered zero flag
//  sign_q      out  1      registered sign flag
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-instruction): all regfile entries, A, B, alu_out, zero_q, sign_q -> 0.
//    Outputs change immediately on rst rise. num1/num2 then follow: ALUSrcA=00 gives pc.
//  - Regfile: 2 async read ports, 1 sync write port. Register 0 always reads 0.
//    Writes to register 0 are discarded. Write lands on the clk edge with reg_we=1.
//  - A/B: on the edge with ab_en=1, A<=rf[rs_addr] and B<=rf[rt_addr]. They hold when ab_en=0.
//    The new value is visible on num1/num2 one cycle later.
//  - ext_imm = ext_op ? {{16{imm16[15]}},imm16} : {16'b0,imm16}. ext_imm<<2 drops the upper 2 bits (mod 2**32).
//  - num1/num2 are purely combinational, with zero latency from select/latch changes.
//    Illegal ALUSrcA=11 drives 0.
//  - ALUOut/flags: on the edge with out_en=1, alu_out<=alu_result, zero_q<=alu_zero, sign_q<=alu_sign.
//    They hold otherwise. ALU is combinational, so result captured is for the operands present that cycle.
//  - Simultaneous reg_we and ab_en to the same address: see CONFIGURATION. Writes to other addresses
//    do not disturb the A/B latch.
//  - Simultaneous out_en and ab_en are independent; both update on the same edge.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: in the same cycle as a write, a read of the write address (non-zero)
//    returns reg_wdata. A/B latched in that cycle get the new value.
//  REGFILE_BYPASS_EN undefined: reads return the stored value. A/B latched in the write cycle
//    get the old value; the new value is readable from the next cycle.
//  Register 0 is never bypassed in either configuration.
// TESTING
//  1 rst pulse mid-run after rf[5]=7, alu_out=9 -> alu_out=0, zero_q=0, rf[5] reads 0, immediately (no clk).
//  2 write rf[0]=32'hFFFF_FFFF, then ab_en with rs=0 -> A=0; ALUSrcA=01 -> num1=0.
//  3 rf[3]=10, rf[4]=3; ab_en, rs=3, rt=4; next cycle ALUSrcA=01, ALUSrcB=00 -> num1=10, num2=3.
//    ALU subu result 7, out_en -> alu_out=7, zero_q=0, sign_q=0.
//  4 imm16=16'h8000, ext_op=1, ALUSrcB=10 -> num2=32'hFFFF_8000; ALUSrcB=11 -> 32'hFFFE_0000.
//    ext_op=0, ALUSrcB=10 -> 32'h0000_8000.
//  5 pc=32'h0040_0000, ALUSrcA=00, ALUSrcB=01 -> num1=0040_0000, num2=4.
//    shamt=5, ALUSrcA=10 -> num1=5.
//  6 rf[8]=1, same edge reg_we addr 8 data 42 and ab_en rs=8 -> A=42 with REGFILE_BYPASS_EN, A=1 without.
//    rf[8]=42 afterwards in both builds.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: regfile, A/B latches, ALU operand muxes and ALUOut/flag capture (optional REGFILE_BYPASS_EN)
module alu_operand_stage #(
  parameter int WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic                  reg_we,
  input  logic [REG_ADDR_W-1:0] reg_waddr,
  input  logic [WIDTH-1:0]      reg_wdata,
  input  logic                  ab_en,
  input  logic [1:0]            ALUSrcA,
  input  logic [1:0]            ALUSrcB,
  input  logic [WIDTH-1:0]      pc,
  input  logic [15:0]           imm16,
  input  logic                  ext_op,
  input  logic [4:0]            shamt,
  output logic [WIDTH-1:0]      num1,
  output logic [WIDTH-1:0]      num2,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_sign,
  input  logic                  out_en,
  output logic [WIDTH-1:0]      alu_out,
  output logic                  zero_q,
  output logic                  sign_q
);
  localparam int DEPTH = 2 ** REG_ADDR_W;
  logic [WIDTH-1:0] rf [DEPTH];
  logic [WIDTH-1:0] a, b, rd1, rd2, ext_imm;
  logic             wr_ok;
  assign wr_ok = reg_we && (reg_waddr != '0);
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    else if (wr_ok)
      rf[reg_waddr] <= reg_wdata;
`ifdef REGFILE_BYPASS_EN
  // wr_ok already excludes register 0, so r0 is never forwarded
  assign rd1 = (wr_ok && reg_waddr == rs_addr) ? reg_wdata : rf[rs_addr];
  assign rd2 = (wr_ok && reg_waddr == rt_addr) ? reg_wdata : rf[rt_addr];
`else
  assign rd1 = rf[rs_addr];
  assign rd2 = rf[rt_addr];
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      if (ab_en) begin
        a <= rd1;
        b <= rd2;
      end
      if (out_en) begin
        alu_out <= alu_result;
        zero_q  <= alu_zero;
        sign_q  <= alu_sign;
      end
    end
  assign ext_imm = ext_op ? {{(WIDTH-16){imm16[15]}}, imm16} : {{(WIDTH-16){1'b0}}, imm16};
  always_comb begin
    num1 = ALUSrcA == 2'b00 ? pc :
           ALUSrcA == 2'b01 ? a :
           ALUSrcA == 2'b10 ? {{(WIDTH-5){1'b0}}, shamt} : '0;
    num2 = ALUSrcB == 2'b00 ? b :
           ALUSrcB == 2'b01 ? WIDTH'(4) :
           ALUSrcB == 2'b10 ? ext_imm : {ext_imm[WIDTH-3:0], 2'b00};
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed vectors, corner sequences and randomized model check
module tb_alu_operand_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, reg_waddr, shamt;
  logic        reg_we, ab_en, ext_op, alu_zero, alu_sign, out_en;
  logic [31:0] reg_wdata, pc, num1, num2, alu_result, alu_out;
  logic [1:0]  ALUSrcA, ALUSrcB;
  logic [15:0] imm16;
  logic        zero_q, sign_q;

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr), .reg_we(reg_we),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .ab_en(ab_en), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .pc(pc), .imm16(imm16), .ext_op(ext_op), .shamt(shamt),
    .num1(num1), .num2(num2), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_sign(alu_sign), .out_en(out_en), .alu_out(alu_out), .zero_q(zero_q), .sign_q(sign_q)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  sa, sb;
    logic [31:0] pcv;
    logic [15:0] imm;
    logic        ext;
    logic [4:0]  sh;
    logic [31:0] e1, e2;
  } vec_t;

  logic [31:0] rf_m [32];
  logic [31:0] a_m, b_m, out_m;
  logic        z_m, s_m;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] ad, input logic [31:0] d);
    reg_we = 1'b1; reg_waddr = ad; reg_wdata = d;
    tick;
    reg_we = 1'b0;
  endtask

  task automatic latch(input logic [4:0] rs, input logic [4:0] rt);
    ab_en = 1'b1; rs_addr = rs; rt_addr = rt;
    tick;
    ab_en = 1'b0;
  endtask

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic ext);
    return ext ? 32'($signed(imm)) : 32'(imm);
  endfunction

  function automatic logic [31:0] ref_num1(input logic [1:0] s, input logic [31:0] p,
                                           input logic [31:0] av, input logic [4:0] sh);
    case (s)
      2'd0: return p;
      2'd1: return av;
      2'd2: return 32'(sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_num2(input logic [1:0] s, input logic [31:0] bv,
                                           input logic [15:0] imm, input logic ext);
    case (s)
      2'd0: return bv;
      2'd1: return 32'd4;
      2'd2: return ref_ext(imm, ext);
      default: return ref_ext(imm, ext) * 32'd4;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] ad, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
`ifdef REGFILE_BYPASS_EN
    if (we && wa == ad && ad != 5'd0) return wd;
`endif
    return rf_m[ad];
  endfunction

  initial begin
    vec_t vt [8];
    logic [31:0] exp6;
    vt[0] = '{2'b00, 2'b10, 32'h0, 16'h8000, 1'b1, 5'd0, 32'h0, 32'hFFFF_8000};
    vt[1] = '{2'b00, 2'b11, 32'h0, 16'h8000, 1'b1, 5'd0, 32'h0, 32'hFFFE_0000};
    vt[2] = '{2'b00, 2'b10, 32'h0, 16'h8000, 1'b0, 5'd0, 32'h0, 32'h0000_8000};
    vt[3] = '{2'b00, 2'b01, 32'h0040_0000, 16'h0, 1'b0, 5'd0, 32'h0040_0000, 32'd4};
    vt[4] = '{2'b10, 2'b01, 32'h0040_0000, 16'h0, 1'b0, 5'd5, 32'd5, 32'd4};
    vt[5] = '{2'b11, 2'b11, 32'h1234_5678, 16'h7FFF, 1'b1, 5'd31, 32'd0, 32'h0001_FFFC};
    vt[6] = '{2'b10, 2'b11, 32'h0, 16'hC001, 1'b0, 5'd31, 32'd31, 32'h0003_0004};
    vt[7] = '{2'b00, 2'b10, 32'hFFFF_FFFC, 16'h1234, 1'b1, 5'd1, 32'hFFFF_FFFC, 32'h0000_1234};

    rst = 1'b1; rs_addr = '0; rt_addr = '0; reg_we = 1'b0; reg_waddr = '0; reg_wdata = '0;
    ab_en = 1'b0; ALUSrcA = 2'b01; ALUSrcB = 2'b00; pc = '0; imm16 = '0; ext_op = 1'b0;
    shamt = '0; alu_result = '0; alu_zero = 1'b0; alu_sign = 1'b0; out_en = 1'b0;
    #12 rst = 1'b0;
    tick;
    chk("reset_num1", num1, 32'd0);
    chk("reset_num2", num2, 32'd0);
    chk("reset_alu_out", alu_out, 32'd0);

    // async reset mid-run clears state without a clock edge
    wr(5'd5, 32'd7);
    alu_result = 32'd9; alu_zero = 1'b1; alu_sign = 1'b1; out_en = 1'b1;
    tick;
    out_en = 1'b0;
    chk("pre_rst_alu_out", alu_out, 32'd9);
    chk("pre_rst_zero", 32'(zero_q), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_alu_out", alu_out, 32'd0);
    chk("async_rst_zero", 32'(zero_q), 32'd0);
    chk("async_rst_sign", 32'(sign_q), 32'd0);
    #2 rst = 1'b0;
    latch(5'd5, 5'd5);
    chk("rst_rf5_num1", num1, 32'd0);
    chk("rst_rf5_num2", num2, 32'd0);

    // register 0 ignores writes
    wr(5'd0, 32'hFFFF_FFFF);
    latch(5'd0, 5'd0);
    chk("r0_num1", num1, 32'd0);

    wr(5'd3, 32'd10);
    wr(5'd4, 32'd3);
    latch(5'd3, 5'd4);
    chk("ab_num1", num1, 32'd10);
    chk("ab_num2", num2, 32'd3);
    alu_result = 32'd7; alu_zero = 1'b0; alu_sign = 1'b0; out_en = 1'b1;
    tick;
    out_en = 1'b0;
    chk("subu_alu_out", alu_out, 32'd7);
    chk("subu_zero", 32'(zero_q), 32'd0);
    chk("subu_sign", 32'(sign_q), 32'd0);

    for (int i = 0; i < 8; i++) begin
      ALUSrcA = vt[i].sa; ALUSrcB = vt[i].sb; pc = vt[i].pcv;
      imm16 = vt[i].imm; ext_op = vt[i].ext; shamt = vt[i].sh;
      #1;
      chk($sformatf("vec%0d_num1", i), num1, vt[i].e1);
      chk($sformatf("vec%0d_num2", i), num2, vt[i].e2);
    end

    // write and latch of the same register on one edge
    wr(5'd8, 32'd1);
`ifdef REGFILE_BYPASS_EN
    exp6 = 32'd42;
`else
    exp6 = 32'd1;
`endif
    reg_we = 1'b1; reg_waddr = 5'd8; reg_wdata = 32'd42;
    ab_en = 1'b1; rs_addr = 5'd8; rt_addr = 5'd0;
    tick;
    reg_we = 1'b0; ab_en = 1'b0;
    ALUSrcA = 2'b01; ALUSrcB = 2'b00;
    #1;
    chk("same_edge_A", num1, exp6);
    chk("same_edge_B_r0", num2, 32'd0);
    latch(5'd8, 5'd8);
    chk("after_wr_A", num1, 32'd42);
    chk("after_wr_B", num2, 32'd42);

    // randomized run against the reference model, starting from a fresh reset
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    a_m = '0; b_m = '0; out_m = '0; z_m = 1'b0; s_m = 1'b0;
    for (int n = 0; n < 400; n++) begin
      reg_we = 1'($urandom); reg_waddr = 5'($urandom_range(0, 7)); reg_wdata = $urandom;
      ab_en = 1'($urandom); rs_addr = 5'($urandom_range(0, 7)); rt_addr = 5'($urandom_range(0, 7));
      if (n % 5 == 0) begin rs_addr = reg_waddr; rt_addr = 5'($urandom); end
      ALUSrcA = 2'($urandom); ALUSrcB = 2'($urandom); pc = $urandom; imm16 = 16'($urandom);
      ext_op = 1'($urandom); shamt = 5'($urandom);
      alu_result = $urandom; alu_zero = 1'($urandom); alu_sign = 1'($urandom); out_en = 1'($urandom);
      #1;
      chk("rand_num1", num1, ref_num1(ALUSrcA, pc, a_m, shamt));
      chk("rand_num2", num2, ref_num2(ALUSrcB, b_m, imm16, ext_op));
      if (ab_en) begin
        a_m = ref_read(rs_addr, reg_we, reg_waddr, reg_wdata);
        b_m = ref_read(rt_addr, reg_we, reg_waddr, reg_wdata);
      end
      if (reg_we && reg_waddr != 5'd0) rf_m[reg_waddr] = reg_wdata;
      if (out_en) begin out_m = alu_result; z_m = alu_zero; s_m = alu_sign; end
      tick;
      chk("rand_alu_out", alu_out, out_m);
      chk("rand_flags", {30'd0, zero_q, sign_q}, {30'd0, z_m, s_m});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
